// File: rtl/uart_pkg.sv
// Types and constants shared between the UART transmitter and its front-end arbiter.
package uart_pkg;

  localparam int UART_FRAME_W = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  // Index width for a requester count; a single requester still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo N_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (!any_valid && valid[cand[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds N_REQ frame requesters into one UART transmitter.
// Handshake: a requester holds req_valid/req_data until req_ack; req_ack means the UART took the frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  N_REQ         = 4,
  parameter int  DATA_W        = UART_FRAME_W,
  parameter int  START_TIMEOUT = 1024,
  localparam int IDX_W         = idx_width(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]             req_ack,
  output logic [N_REQ-1:0]             req_done,
  output logic                         uart_start,
  output logic [DATA_W-1:0]            uart_data,
  input  logic                         uart_ready,
  input  logic                         uart_busy,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         active,
  output logic                         timeout_err,
  output arb_state_t                   dbg_state
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         grant_id_q, grant_id_d;
  logic                     uart_start_q, uart_start_d;
  logic [DATA_W-1:0]        uart_data_q, uart_data_d;
  logic [N_REQ-1:0]         req_ack_q, req_ack_d;
  logic [N_REQ-1:0]         req_done_q, req_done_d;
  logic                     active_q, active_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [15:0]              cnt_q, cnt_d;

  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) >= N_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    uart_start_d  = uart_start_q;
    uart_data_d   = uart_data_q;
    cnt_d         = cnt_q;
    req_ack_d     = '0;
    req_done_d    = '0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any && uart_ready) begin
          state_d      = START;
          grant_id_d   = pick_idx;
          uart_data_d  = req_data[pick_idx];
          uart_start_d = 1'b1;
          cnt_d        = '0;
        end
      end
      // The transmitter samples start only on its baud tick, so hold it until busy shows up.
      START: begin
        if (uart_busy) begin
          uart_start_d          = 1'b0;
          req_ack_d[grant_id_q] = 1'b1;
          state_d               = WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          uart_start_d  = 1'b0;
          timeout_err_d = 1'b1;
          ptr_d         = next_idx(grant_id_q);
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy && uart_ready) begin
          req_done_d[grant_id_q] = 1'b1;
          ptr_d                  = next_idx(grant_id_q);
          state_d                = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        uart_start_d = 1'b0;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      uart_start_q  <= 1'b0;
      uart_data_q   <= '0;
      req_ack_q     <= '0;
      req_done_q    <= '0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      uart_start_q  <= uart_start_d;
      uart_data_q   <= uart_data_d;
      req_ack_q     <= req_ack_d;
      req_done_q    <= req_done_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign req_done    = req_done_q;
  assign uart_start  = uart_start_q;
  assign uart_data   = uart_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

endmodule
